// File: rtl/instr_stream_encoder.sv
// RV32 instruction encoder and program loader: packs field-level requests into
// instruction words and streams them to consecutive instruction-memory addresses.
module instr_stream_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [31:0]      i_base_addr,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_format,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [31:0]      i_imm,
    output logic             o_wr_en,
    input  logic             i_wr_ready,
    output logic [31:0]      o_wr_addr,
    output logic [31:0]      o_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [CNT_W-1:0] o_err_index
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] err_index_q, err_index_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        retire;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (i_format)
            3'd0: enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            3'd1: begin
                enc_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                enc_legal = (i_imm[31:11] == {21{i_imm[11]}});
            end
            3'd2: begin
                enc_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                enc_legal = (i_imm[31:11] == {21{i_imm[11]}});
            end
            3'd3: begin
                enc_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
                enc_legal = (i_imm[31:12] == {20{i_imm[12]}}) && !i_imm[0];
            end
            3'd4: begin
                enc_word  = {i_imm[31:12], i_rd, i_opcode};
                enc_legal = (i_imm[11:0] == 12'h0);
            end
            3'd5: begin
                enc_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                enc_legal = (i_imm[31:20] == {12{i_imm[20]}}) && !i_imm[0];
            end
            default: enc_legal = 1'b0;
        endcase
    end

    // Single output register: a new word may enter whenever the held one leaves.
    assign o_ready = (state_q == StLoad) && (!wr_en_q || i_wr_ready);
    assign accept  = i_valid && o_ready;
    assign retire  = wr_en_q && i_wr_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_index_d = err_index_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        addr_d      = i_base_addr & ~32'd3;
                        remaining_d = i_count;
                        index_d     = '0;
                        error_d     = 1'b0;
                        err_index_d = '0;
                        state_d     = StLoad;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (retire) begin
                    wr_en_d = 1'b0;
                end
                if (accept) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = enc_legal ? enc_word : Nop;
                    addr_d      = addr_q + 32'd4;
                    index_d     = index_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (!enc_legal) begin
                        error_d = 1'b1;
                        if (!error_q) begin
                            err_index_d = index_q;
                        end
                    end
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (retire) begin
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            addr_q      <= 32'h0;
            remaining_q <= '0;
            index_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 32'h0;
            wr_data_q   <= 32'h0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_busy      = (state_q != StIdle);
    assign o_done      = done_q;
    assign o_error     = error_q;
    assign o_err_index = err_index_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: expected {addr, word} pairs are queued on
// each accepted request and compared as the writes retire.
module tb_instr_stream_encoder;

    localparam int CW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [31:0]   i_base_addr = 32'h0;
    logic [CW-1:0] i_count = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [2:0]    i_format = 3'd0;
    logic [6:0]    i_opcode = 7'h0;
    logic [2:0]    i_funct3 = 3'h0;
    logic [6:0]    i_funct7 = 7'h0;
    logic [4:0]    i_rd = 5'h0;
    logic [4:0]    i_rs1 = 5'h0;
    logic [4:0]    i_rs2 = 5'h0;
    logic [31:0]   i_imm = 32'h0;
    logic          o_wr_en;
    logic          i_wr_ready = 1'b1;
    logic [31:0]   o_wr_addr;
    logic [31:0]   o_wr_data;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic [CW-1:0] o_err_index;

    instr_stream_encoder #(.CNT_W(CW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_format    (i_format),
        .i_opcode    (i_opcode),
        .i_funct3    (i_funct3),
        .i_funct7    (i_funct7),
        .i_rd        (i_rd),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_imm       (i_imm),
        .o_wr_en     (o_wr_en),
        .i_wr_ready  (i_wr_ready),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_err_index (o_err_index)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_addr = 32'h0;

    task automatic do_start(input logic [31:0] base, input logic [CW-1:0] count);
        @(posedge i_clk); #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_count     = count;
        m_addr      = base & ~32'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    // Presents one request, waits for the handshake and queues the expected write.
    task automatic send_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            input logic [31:0] exp_word);
        int t = 0;
        i_format = fmt; i_opcode = op; i_funct3 = f3; i_funct7 = f7;
        i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
        end else begin
            sb_q.push_back({m_addr, exp_word});
            m_addr += 32'd4;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    // Retires n writes, optionally stalling the given word, popping the scoreboard.
    task automatic collect(input string name, input int n, input int stall_word,
                           input int stall_len, input bit no_gaps);
        int got = 0;
        int stalled = 0;
        int cyc = 0;
        int last = -1;
        logic [63:0] e;
        while (got < n && cyc < 300) begin
            @(posedge i_clk); #1;
            cyc++;
            i_wr_ready = !(o_wr_en && got == stall_word && stalled < stall_len);
            @(negedge i_clk);
            if (o_wr_en && !i_wr_ready) begin
                stalled++;
                checks++;
                if (sb_q.size() == 0 || o_ready !== 1'b0 || {o_wr_addr, o_wr_data} !== sb_q[0]) begin
                    failures++;
                    $display("FAIL %s_stall_hold: ready=%b addr=%h data=%h required ready=0 %h",
                             name, o_ready, o_wr_addr, o_wr_data,
                             (sb_q.size() != 0) ? sb_q[0] : 64'h0);
                end
            end else if (o_wr_en) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra_write: addr=%h data=%h required no write",
                             name, o_wr_addr, o_wr_data);
                end else begin
                    e = sb_q.pop_front();
                    if ({o_wr_addr, o_wr_data} !== e) begin
                        failures++;
                        $display("FAIL %s_word%0d: addr=%h data=%h required addr=%h data=%h",
                                 name, got, o_wr_addr, o_wr_data, e[63:32], e[31:0]);
                    end
                end
                if (no_gaps && last >= 0) begin
                    checks++;
                    if (cyc != last + 1) begin
                        failures++;
                        $display("FAIL %s_bubble: gap=%0d cycles required 1", name, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
        end
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s_write_count: got=%0d required %0d", name, got, n);
        end
    endtask

    task automatic test_reset;
        #12;
        checks += 4;
        if (o_ready !== 1'b0 || o_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: ready=%b wr_en=%b required 0 0", o_ready, o_wr_en);
        end
        if (o_wr_addr !== 32'h0 || o_wr_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_wr: addr=%h data=%h required 0 0", o_wr_addr, o_wr_data);
        end
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b required 0 0", o_busy, o_done);
        end
        if (o_error !== 1'b0 || o_err_index !== '0) begin
            failures++;
            $display("FAIL reset_err: error=%b idx=%0d required 0 0", o_error, o_err_index);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b ready=%b required 0 0", o_busy, o_ready);
        end
    endtask

    task automatic test_single;
        do_start(32'h100, 16'd1);
        checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_load: busy=%b ready=%b required 1 1", o_busy, o_ready);
        end
        fork
            send_req(3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
            collect("single", 1, -1, 0, 1'b0);
        join
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_error !== 1'b0) begin
            failures++;
            $display("FAIL single_done: done=%b busy=%b error=%b required 1 0 0",
                     o_done, o_busy, o_error);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_pulse: done=%b required 0", o_done);
        end
    endtask

    task automatic run_three(input string name, input int stall_len);
        do_start(32'h200, 16'd3);
        fork
            begin
                send_req(3'd3, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463);
                send_req(3'd4, 7'h37, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7);
                send_req(3'd5, 7'h6F, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF);
            end
            collect(name, 3, 1, stall_len, stall_len == 0);
        join
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_end: done=%b busy=%b pending=%0d required 1 0 0",
                     name, o_done, o_busy, sb_q.size());
        end
    endtask

    task automatic test_back_to_back;
        run_three("b2b", 0);
    endtask

    task automatic test_backpressure;
        run_three("bp", 3);
    endtask

    task automatic test_error;
        do_start(32'h300, 16'd5);
        fork
            begin
                send_req(3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
                send_req(3'd0, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
                send_req(3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013);
                send_req(3'd6, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0000_0013);
                send_req(3'd3, 7'h63, 3'd1, 7'h0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_9EE3);
            end
            begin
                collect("err_a", 2, -1, 0, 1'b0);
                checks++;
                if (o_error !== 1'b0) begin
                    failures++;
                    $display("FAIL err_early: error=%b required 0", o_error);
                end
                collect("err_b", 1, -1, 0, 1'b0);
                checks++;
                if (o_error !== 1'b1 || o_err_index !== 16'd2) begin
                    failures++;
                    $display("FAIL err_first: error=%b idx=%0d required 1 2", o_error, o_err_index);
                end
                collect("err_c", 2, -1, 0, 1'b0);
            end
        join
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_error !== 1'b1 || o_err_index !== 16'd2) begin
            failures++;
            $display("FAIL err_hold: done=%b error=%b idx=%0d required 1 1 2",
                     o_done, o_error, o_err_index);
        end
    endtask

    task automatic test_wrap;
        do_start(32'hFFFF_FFFE, 16'd2);
        checks++;
        if (o_error !== 1'b0 || o_err_index !== '0) begin
            failures++;
            $display("FAIL wrap_err_clear: error=%b idx=%0d required 0 0", o_error, o_err_index);
        end
        fork
            begin
                send_req(3'd2, 7'h23, 3'd2, 7'h0, 5'd0, 5'd1, 5'd2, 32'd12, 32'h0020_A623);
                send_req(3'd0, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
            end
            collect("wrap", 2, -1, 0, 1'b0);
        join
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done: done=%b required 1", o_done);
        end
    endtask

    task automatic test_count_zero;
        do_start(32'h400, 16'd0);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: done=%b busy=%b wr_en=%b required 1 0 0",
                     o_done, o_busy, o_wr_en);
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_done !== 1'b0 || o_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse: done=%b wr_en=%b required 0 0", o_done, o_wr_en);
        end
    endtask

    task automatic test_start_ignored;
        do_start(32'h500, 16'd2);
        fork
            begin
                send_req(3'd4, 7'h37, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7);
                i_start = 1'b1; i_base_addr = 32'h900; i_count = 16'd7;
                @(posedge i_clk); #1;
                i_start = 1'b0;
                send_req(3'd5, 7'h6F, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF);
            end
            collect("ign", 2, -1, 0, 1'b0);
        join
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_done: done=%b busy=%b required 1 0", o_done, o_busy);
        end
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL ign_restart: busy=%b wr_en=%b required 0 0", o_busy, o_wr_en);
        end
    endtask

    task automatic test_reset_mid;
        do_start(32'h600, 16'd5);
        fork
            begin
                send_req(3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
                send_req(3'd0, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
                send_req(3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013);
            end
            collect("rstmid", 2, -1, 0, 1'b0);
        join
        #1;
        checks++;
        if (o_wr_en !== 1'b1 || o_busy !== 1'b1 || o_error !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pending: wr_en=%b busy=%b error=%b required 1 1 1",
                     o_wr_en, o_busy, o_error);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_error, o_err_index}
            !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: ready=%b wr_en=%b addr=%h data=%h busy=%b done=%b err=%b idx=%0d required all 0",
                     o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_error, o_err_index);
        end
        sb_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) begin
            @(negedge i_clk);
            checks++;
            if (o_done !== 1'b0 || o_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_quiet: done=%b wr_en=%b required 0 0", o_done, o_wr_en);
            end
        end
        do_start(32'h40, 16'd1);
        fork
            send_req(3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
            collect("rstmid_new", 1, -1, 0, 1'b0);
        join
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_error !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_new_done: done=%b error=%b required 1 0", o_done, o_error);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_error;
        test_wrap;
        test_count_zero;
        test_start_ignored;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
